fifo_bram_writer: RTL and testbench

FIFO_BRAM_WRITER -- requirements
Module: fifo_bram_writer

---
 rtl/fifo_bram_pkg.sv | 12 +
 rtl/fifo_bram_writer.sv | 183 ++++++++++++++++++
 tb/tb_fifo_bram_writer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_bram_pkg.sv
// Shared FSM encoding and default geometry for the FIFO-to-BRAM ping-pong writer.
package fifo_bram_pkg;

  localparam int ADDR_W_DEFAULT = 12;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WRITE    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_bram_writer.sv
// Drains a FWFT FIFO into a BRAM split into two halves that are handed to the PS
// in ping-pong fashion; each published half raises half_ready and pulses irq.
module fifo_bram_writer
  import fifo_bram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [31:0]       fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_din,
  input  logic [1:0]        half_ack,
  output logic [1:0]        half_ready,
  output logic [ADDR_W-1:0] half_count0,
  output logic [ADDR_W-1:0] half_count1,
  output logic              irq,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       words_written
);

  localparam int                PTR_W    = ADDR_W - 1;
  localparam logic [PTR_W-1:0]  PTR_LAST = {PTR_W{1'b1}};

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_e            state_q, state_d;
  logic              cur_half_q, cur_half_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]        half_ready_q, half_ready_d;
  logic [ADDR_W-1:0] half_count0_q, half_count0_d;
  logic [ADDR_W-1:0] half_count1_q, half_count1_d;
  logic              irq_q, irq_d;
  logic              bram_wr_q, bram_wr_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [31:0]       bram_din_q, bram_din_d;
  logic [31:0]       stall_q, stall_d;
  logic [31:0]       words_q, words_d;

  logic              pop_s;
  logic              full_s;
  logic              publish_s;
  logic [ADDR_W-1:0] fill_s;

  // fill_s is the word count of the current half including this cycle's pop,
  // so a pop into the last slot yields exactly HALF_WORDS.
  assign pop_s  = !rst && (state_q == ST_WRITE) && !fifo_empty && !half_ready_q[cur_half_q];
  assign full_s = pop_s && (wr_ptr_q == PTR_LAST);
  assign fill_s = {1'b0, wr_ptr_q} + {{PTR_W{1'b0}}, pop_s};

  assign fifo_rd_en = pop_s;

  // Next-state: FSM, write pipeline, half bookkeeping and status counters.
  always_comb begin
    state_d       = state_q;
    cur_half_d    = cur_half_q;
    half_count0_d = half_count0_q;
    half_count1_d = half_count1_q;
    stall_d       = stall_q;
    irq_d         = 1'b0;
    publish_s     = 1'b0;
    bram_wr_d     = pop_s;
    half_ready_d  = half_ready_q & ~half_ack;

    if (pop_s) begin
      bram_addr_d = {cur_half_q, wr_ptr_q};
      bram_din_d  = fifo_rd_data;
      wr_ptr_d    = wr_ptr_q + 1'b1;
      words_d     = sat_inc(words_q);
    end else begin
      bram_addr_d = bram_addr_q;
      bram_din_d  = bram_din_q;
      wr_ptr_d    = wr_ptr_q;
      words_d     = words_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = half_ready_d[cur_half_q] ? ST_WAIT_ACK : ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (full_s) begin
          publish_s = 1'b1;
          if (!enable) begin
            state_d = ST_IDLE;
          end else if (half_ready_d[~cur_half_q]) begin
            state_d = ST_WAIT_ACK;
          end else begin
            state_d = ST_WRITE;
          end
        end else if (!enable) begin
          // A word popped in this same cycle is still counted into the partial half.
          publish_s = (fill_s != {ADDR_W{1'b0}});
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_WAIT_ACK: begin
        stall_d = sat_inc(stall_q);
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (!half_ready_d[cur_half_q]) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_WAIT_ACK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Publishing is applied after the ack clear so that a same-cycle set wins.
    if (publish_s) begin
      half_ready_d[cur_half_q] = 1'b1;
      if (cur_half_q) begin
        half_count1_d = fill_s;
      end else begin
        half_count0_d = fill_s;
      end
      irq_d      = 1'b1;
      cur_half_d = ~cur_half_q;
      wr_ptr_d   = {PTR_W{1'b0}};
    end else begin
      irq_d = 1'b0;
    end
  end

  // State and registered outputs; reset also discards any in-flight BRAM write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cur_half_q    <= 1'b0;
      wr_ptr_q      <= {PTR_W{1'b0}};
      half_ready_q  <= 2'b00;
      half_count0_q <= {ADDR_W{1'b0}};
      half_count1_q <= {ADDR_W{1'b0}};
      irq_q         <= 1'b0;
      bram_wr_q     <= 1'b0;
      bram_addr_q   <= {ADDR_W{1'b0}};
      bram_din_q    <= 32'h0000_0000;
      stall_q       <= 32'h0000_0000;
      words_q       <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      cur_half_q    <= cur_half_d;
      wr_ptr_q      <= wr_ptr_d;
      half_ready_q  <= half_ready_d;
      half_count0_q <= half_count0_d;
      half_count1_q <= half_count1_d;
      irq_q         <= irq_d;
      bram_wr_q     <= bram_wr_d;
      bram_addr_q   <= bram_addr_d;
      bram_din_q    <= bram_din_d;
      stall_q       <= stall_d;
      words_q       <= words_d;
    end
  end

  assign bram_en       = bram_wr_q;
  assign bram_we       = bram_wr_q;
  assign bram_addr     = bram_addr_q;
  assign bram_din      = bram_din_q;
  assign half_ready    = half_ready_q;
  assign half_count0   = half_count0_q;
  assign half_count1   = half_count1_q;
  assign irq           = irq_q;
  assign stall_cycles  = stall_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_fifo_bram_writer.sv
// Scoreboard bench: expected BRAM writes are queued as words enter the FIFO model;
// a negedge monitor checks every write the DUT presents.
module tb_fifo_bram_writer;

  localparam int AW   = 4;
  localparam int HALF = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          fifo_empty;
  logic [31:0]   fifo_rd_data;
  logic          fifo_rd_en;
  logic          bram_en;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_din;
  logic [1:0]    half_ack;
  logic [1:0]    half_ready;
  logic [AW-1:0] half_count0;
  logic [AW-1:0] half_count1;
  logic          irq;
  logic [31:0]   stall_cycles;
  logic [31:0]   words_written;

  always #5 clk = ~clk;

  fifo_bram_writer #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .half_ack(half_ack), .half_ready(half_ready),
    .half_count0(half_count0), .half_count1(half_count1), .irq(irq),
    .stall_cycles(stall_cycles), .words_written(words_written)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] fifo_q[$];
  wr_t         exp_q[$];
  int          irq_seen = 0;
  int          pops = 0;

  // Reference model: words fill halves in arrival order; publish on full or on disable.
  int          m_half, m_off, m_irq, m_words;
  logic [1:0]  m_ready;
  int          m_count[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_half = 0; m_off = 0; m_irq = 0; m_words = 0; m_ready = 2'b00;
    m_count[0] = 0; m_count[1] = 0;
  endtask

  task automatic model_publish(input int cnt);
    m_ready[m_half] = 1'b1;
    m_count[m_half] = cnt;
    m_irq++;
    m_half = 1 - m_half;
    m_off  = 0;
  endtask

  task automatic drive_fifo();
    fifo_empty   = (fifo_q.size() == 0);
    fifo_rd_data = (fifo_q.size() == 0) ? 32'h0 : fifo_q[0];
  endtask

  task automatic push_word(input logic [31:0] d);
    wr_t w;
    w.addr = AW'(m_half * HALF + m_off);
    w.data = d;
    fifo_q.push_back(d);
    exp_q.push_back(w);
    m_off++;
    m_words++;
    if (m_off == HALF) model_publish(HALF);
  endtask

  task automatic push_burst(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) push_word(base + 32'(i));
    drive_fifo();
  endtask

  task automatic tick();
    logic p;
    @(negedge clk);
    p = fifo_rd_en;
    @(posedge clk);
    #1;
    if (p && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    drive_fifo();
  endtask

  task automatic ack(input logic [1:0] m);
    half_ack = m;
    tick();
    half_ack = 2'b00;
    m_ready  = m_ready & ~m;
  endtask

  task automatic set_enable(input logic v);
    if (!v && enable && m_off > 0) model_publish(m_off);
    enable = v;
    tick();
  endtask

  task automatic quiet();
    int n = 0;
    while (fifo_q.size() > 0 && n < 400) begin
      tick();
      n++;
    end
    if (fifo_q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d words left in fifo, expected 0", fifo_q.size());
    end
    repeat (3) tick();
    check("pending_writes", exp_q.size(), 0);
  endtask

  task automatic check_state();
    check("half_ready", {30'd0, half_ready}, {30'd0, m_ready});
    check("half_count0", {28'd0, half_count0}, m_count[0]);
    check("half_count1", {28'd0, half_count1}, m_count[1]);
    check("irq_pulses", irq_seen, m_irq);
    check("words_written", words_written, m_words);
  endtask

  task automatic check_reset();
    check("rst_bram_en", {31'd0, bram_en}, 32'd0);
    check("rst_bram_we", {31'd0, bram_we}, 32'd0);
    check("rst_bram_addr", {28'd0, bram_addr}, 32'd0);
    check("rst_bram_din", bram_din, 32'd0);
    check("rst_half_ready", {30'd0, half_ready}, 32'd0);
    check("rst_half_count0", {28'd0, half_count0}, 32'd0);
    check("rst_half_count1", {28'd0, half_count1}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_stall", stall_cycles, 32'd0);
    check("rst_words", words_written, 32'd0);
  endtask

  // Monitor: every presented BRAM write must match the head of the expected queue.
  always @(negedge clk) begin : mon
    wr_t e;
    if (bram_we === 1'b1) begin
      check("bram_en_with_we", {31'd0, bram_en}, 32'd1);
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write", bram_addr, bram_din);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {28'd0, bram_addr}, {28'd0, e.addr});
        check("wr_data", bram_din, e.data);
      end
    end
    if (irq === 1'b1) irq_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s0;
    int          cap, n, p0;
    logic [1:0]  am;

    rst = 1'b1; enable = 1'b0; half_ack = 2'b00;
    model_reset();
    drive_fifo();
    repeat (2) tick();
    check_reset();
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    rst = 1'b0;
    tick();

    // First half fills and publishes.
    set_enable(1'b1);
    push_burst(8, 32'h100);
    quiet();
    check_state();
    check("first_ready", {30'd0, half_ready}, 32'd1);

    // Ack of a half that is not ready is ignored.
    ack(2'b10);
    tick();
    check_state();

    // Second half fills, both owned by PS: writer stalls until half 0 is released.
    push_burst(8, 32'h200);
    quiet();
    check_state();
    m_ready[0] = 1'b0;
    push_burst(8, 32'h208);
    repeat (3) tick();
    check("stuck_fifo_level", fifo_q.size(), 8);
    check("stuck_ready", {30'd0, half_ready}, 32'd3);
    s0 = stall_cycles;
    repeat (10) tick();
    check("stall_delta", stall_cycles - s0, 32'd10);
    check("stuck_words", words_written, 32'd16);
    half_ack = 2'b01;
    tick();
    half_ack = 2'b00;
    quiet();
    check_state();
    ack(2'b10);

    // Partial half published when enable drops; next run restarts at a half start.
    push_burst(3, 32'h300);
    quiet();
    set_enable(1'b0);
    repeat (2) tick();
    check_state();
    set_enable(1'b1);
    ack(2'b01);
    push_burst(2, 32'h310);
    quiet();
    check_state();

    // Randomised traffic, acks and enable toggles at quiet points.
    for (int it = 0; it < 25; it++) begin
      am = 2'($urandom_range(0, 3));
      if (am != 2'b00) ack(am);
      if ($urandom_range(0, 3) == 0) set_enable(!enable);
      if (enable) begin
        if (m_ready[m_half]) cap = 0;
        else begin
          cap = HALF - m_off;
          if (!m_ready[1 - m_half]) cap += HALF;
        end
        n = $urandom_range(0, cap);
        for (int k = 0; k < n; k++) push_word($urandom);
        drive_fifo();
      end
      quiet();
      check_state();
    end

    // Reset in the middle of a burst: no write for the sixth word.
    ack(2'b11);
    if (!enable) set_enable(1'b1);
    quiet();
    p0 = pops;
    push_burst(10, 32'h500);
    n = 0;
    while (pops < p0 + 5 && n < 100) begin
      tick();
      n++;
    end
    check("pops_before_rst", pops - p0, 5);
    rst = 1'b1;
    #1;
    check("rd_en_in_rst", {31'd0, fifo_rd_en}, 32'd0);
    tick();
    check_reset();
    check("writes_left_at_rst", exp_q.size(), 5);
    exp_q.delete();
    fifo_q.delete();
    drive_fifo();
    model_reset();
    irq_seen = 0;
    tick();
    rst = 1'b0;
    tick();
    check_reset();
    push_burst(3, 32'h600);
    quiet();
    check_state();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
